// File: rtl/nios_system_sdram_switch_debounce.sv
// ---------------------------------------------------------------------------
// nios_system_sdram_switch_debounce
//
// Synchronizes and debounces the board slide switches, one bit at a time,
// before they reach the switches PIO in_port. Software sees only clean,
// stable levels. It never sees metastable or bouncing values.
//
// Each bit has three stages:
//   1. A two-flop synchronizer (s1 -> s2). Only s2 is used downstream.
//   2. A private counter that advances while s2 differs from the accepted level.
//      The counter returns to zero whenever s2 goes back to the accepted level.
//   3. The accepted level (sw_out). It takes the s2 value after s2 has differed
//      for DEBOUNCE_CYCLES consecutive compares.
// If a new level holds from the first edge k that samples it, sw_out updates
// on edge k + DEBOUNCE_CYCLES + 1.
//
// Parameters:
//   WIDTH            number of switch bits
//   DEBOUNCE_CYCLES  stable clocks required before a new level is accepted (>= 1)
//   CNT_W            counter width; 2**CNT_W must be >= DEBOUNCE_CYCLES
//
// Ports:
//   clk           in   1      system clock
//   reset_n       in   1      asynchronous active-low reset. It is asserted
//                             asynchronously. The system reset controller is
//                             expected to release it synchronously to clk.
//   sw_in         in   WIDTH  raw switch levels, asynchronous to clk
//   sw_out        out  WIDTH  debounced levels, registered
//   change_pulse  out  WIDTH  one-cycle strobe on each sw_out toggle, registered
//                             (present only when the optional feature is built)
//
// Optional feature macro: SWITCH_DEBOUNCE_CHANGE_PULSE_EN
//   Defined   -> adds the change_pulse port and its logic.
//   Undefined -> the port and its logic are absent. Everything else is identical.
// ---------------------------------------------------------------------------
module nios_system_sdram_switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  ,
  output logic [WIDTH-1:0] change_pulse
`endif
);

  // Terminal count. The compare is exact and unsigned. Because the counter
  // stops at this value, it can never wrap.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic             s1_q;
      logic             s2_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             out_q;
      logic             out_d;

      always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (s2_q == out_q) begin
          // The input is back at (or still at) the accepted level.
          // Any partial count is discarded, so a bounce restarts the count.
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          out_d = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          cnt_q <= '0;
          out_q <= 1'b0;
        end else begin
          s1_q  <= sw_in[gi];
          s2_q  <= s1_q;
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign sw_out[gi] = out_q;

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
      logic pulse_q;
      logic pulse_d;

      // The strobe register loads on the same edge that out_q toggles.
      // It therefore rises together with the new sw_out level.
      always_comb begin
        pulse_d = (out_d != out_q);
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= pulse_d;
        end
      end

      assign change_pulse[gi] = pulse_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_nios_system_sdram_switch_debounce.sv
// ---------------------------------------------------------------------------
// Directed testbench for nios_system_sdram_switch_debounce.
// The DUT is built with DEBOUNCE_CYCLES=4 and CNT_W=3.
//
// Timing used throughout: inputs change 1 ns after a rising edge, so the
// next edge is edge k, the first edge that samples the new level.
// Each tick() call advances to 1 ns after the following rising edge.
// After n ticks the bench therefore observes the state just after edge
// k+n-1. A held level must appear after 6 ticks (edge k+5) and not after
// 5 ticks (edge k+4).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nios_system_sdram_switch_debounce;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  logic [WIDTH-1:0] change_pulse;
`endif

  int total = 0;
  int bad   = 0;

  nios_system_sdram_switch_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_in       (sw_in),
    .sw_out      (sw_out)
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    ,
    .change_pulse(change_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp)
      $display("check %-24s obs=%02h exp=%02h ok", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- 1: reset with switches already high --------------------------
    reset_n = 1'b0;
    sw_in   = 8'hFF;
    tick(3);
    check("reset_sw_out", sw_out, 8'h00);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("reset_pulse", change_pulse, 8'h00);
`endif
    reset_n = 1'b1;
    tick(5);
    check("t1_edge_k4", sw_out, 8'h00);
    tick(1);
    check("t1_edge_k5", sw_out, 8'hFF);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t1_pulse_on", change_pulse, 8'hFF);
`endif
    tick(1);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t1_pulse_off", change_pulse, 8'h00);
`endif
    check("t1_hold", sw_out, 8'hFF);

    // Return everything low (a falling change also takes k+5).
    sw_in = 8'h00;
    tick(5);
    check("fall_edge_k4", sw_out, 8'hFF);
    tick(1);
    check("fall_edge_k5", sw_out, 8'h00);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("fall_pulse", change_pulse, 8'hFF);
`endif
    tick(2);

    // ---- 2: bit0 rises and holds --------------------------------------
    sw_in = 8'h01;
    tick(5);
    check("t2_edge_k4", sw_out, 8'h00);
    tick(1);
    check("t2_edge_k5", sw_out, 8'h01);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t2_pulse", change_pulse, 8'h01);
`endif
    sw_in = 8'h00;
    tick(6);
    check("t2_back_low", sw_out, 8'h00);
    tick(2);

    // ---- 3: bit0 bounces 1,0,1,0, then holds 1 -----------------------
    sw_in = 8'h01; tick(1);
    sw_in = 8'h00; tick(1);
    check("t3_bounce_a", sw_out, 8'h00);
    sw_in = 8'h01; tick(1);
    sw_in = 8'h00; tick(1);
    check("t3_bounce_b", sw_out, 8'h00);
    sw_in = 8'h01;             // final transition, then held
    tick(2);
    check("t3_bounce_tail", sw_out, 8'h00);
    tick(3);
    check("t3_edge_k4", sw_out, 8'h00);
    tick(1);
    check("t3_edge_k5", sw_out, 8'h01);
    sw_in = 8'h00;
    tick(6);
    check("t3_back_low", sw_out, 8'h00);
    tick(2);

    // ---- 4: bit3 high for only 3 synced cycles ------------------------
    sw_in = 8'h08;
    tick(3);
    sw_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("t4_short_%0d", i), sw_out, 8'h00);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
      check($sformatf("t4_pulse_%0d", i), change_pulse, 8'h00);
`endif
    end

    // ---- 5: bits 1 and 6 change together ------------------------------
    sw_in = 8'h42;
    tick(5);
    check("t5_edge_k4", sw_out, 8'h00);
    tick(1);
    check("t5_edge_k5", sw_out, 8'h42);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t5_pulse_on", change_pulse, 8'h42);
`endif
    tick(1);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t5_pulse_off", change_pulse, 8'h00);
`endif
    check("t5_hold", sw_out, 8'h42);

    // ---- 6: reset while bit0 has reached cnt=3 ------------------------
    sw_in = 8'h43;
    tick(5);                   // just past edge k+4: bit0 count is 3
    check("t6_pending", sw_out, 8'h42);
    #2 reset_n = 1'b0;         // mid-cycle, no clock edge involved
    #1;
    check("t6_async_rst", sw_out, 8'h00);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t6_rst_pulse", change_pulse, 8'h00);
`endif
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("t6_edge_k4", sw_out, 8'h00);
    tick(1);
    check("t6_edge_k5", sw_out, 8'h43);
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    check("t6_pulse", change_pulse, 8'h43);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
